result_bcd_converter: RTL and testbench

//   Converts a signed binary result from the CORDIC function units into sign +

---
 rtl/result_bcd_converter_if.sv | 18 +
 rtl/result_bcd_converter.sv | 112 +++++++++++
 tb/tb_result_bcd_converter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/result_bcd_converter_if.sv
// Handshake bundle between a result producer and the BCD converter.
//   start/value : request and binary operand (master -> slave)
//   busy/done   : conversion in progress / one-cycle completion pulse
//   neg/bcd     : sign flag and packed BCD magnitude, [3:0] = least significant digit
interface result_bcd_converter_if #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [IN_W-1:0]       value;
  logic                  busy;
  logic                  done;
  logic                  neg;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, output value, input busy, input done, input neg, input bcd);
  modport slave  (input start, input value, output busy, output done, output neg, output bcd);
endinterface

// File: rtl/result_bcd_converter.sv
// Sequential shift-add-3 (double-dabble) converter: signed or unsigned binary
// result -> sign flag + packed BCD magnitude, one shift per clock.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous reset, active-high
//   bus : slave side of result_bcd_converter_if (start/value in; busy/done/neg/bcd out)
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; value captured into r_work on accept
// S_ABS   | take magnitude of r_work, latch sign, clear scratch, load counter
// S_SHIFT | adjust digits >=5 by +3, shift {scratch,work} left; exit at count 0
// S_DONE  | done pulse cycle; bcd/neg already updated, back to idle
module result_bcd_converter #(
  parameter int IN_W      = 16,
  parameter int DIGITS    = 5,
  parameter bit SIGNED_IN = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  result_bcd_converter_if.slave bus
);
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_ABS, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  logic [IN_W-1:0]    r_work;
  logic [BCD_W-1:0]   r_scratch;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_work;
  logic               r_busy;
  logic               r_done;
  logic               r_neg;
  logic [BCD_W-1:0]   r_bcd;
  logic [BCD_W-1:0]   w_adj;

  // Digit correction ahead of each shift so no digit overflows past 9.
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_work     <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_neg_work <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_neg      <= 1'b0;
      r_bcd      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_work  <= bus.value;
            r_busy  <= 1'b1;
            r_state <= S_ABS;
          end
        end
        S_ABS: begin
          // -2^(IN_W-1) negates to itself, which read unsigned is the right magnitude.
          if (SIGNED_IN && r_work[IN_W-1]) begin
            r_neg_work <= 1'b1;
            r_work     <= -r_work;
          end else begin
            r_neg_work <= 1'b0;
          end
          r_scratch <= '0;
          r_cnt     <= CNT_W'(IN_W);
          r_state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_cnt == '0) begin
            r_bcd   <= r_scratch;
            r_neg   <= r_neg_work;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_scratch <= {w_adj[BCD_W-2:0], r_work[IN_W-1]};
            r_work    <= {r_work[IN_W-2:0], 1'b0};
            r_cnt     <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          // start is ignored here; the next request is taken in IDLE.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.neg  = r_neg;
  assign bus.bcd  = r_bcd;
endmodule

// File: tb/tb_result_bcd_converter.sv
module tb_result_bcd_converter;
  localparam int LAT = 18;

  typedef struct {
    logic [19:0] bcd;
    logic        neg;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_seen = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   busy_from = -100;
  int   busy_until = -100;

  exp_t        q[2][$];
  logic [19:0] m_bcd[2];
  logic        m_neg[2];

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  result_bcd_converter_if #(.IN_W(16), .DIGITS(5)) bus_s ();
  result_bcd_converter_if #(.IN_W(16), .DIGITS(5)) bus_u ();

  result_bcd_converter #(.IN_W(16), .DIGITS(5), .SIGNED_IN(1'b1)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s));
  result_bcd_converter #(.IN_W(16), .DIGITS(5), .SIGNED_IN(1'b0)) dut_u (
    .clk(clk), .rst(rst), .bus(bus_u));

  // Reference: decimal digits of the magnitude by repeated division.
  function automatic logic [19:0] to_bcd(input int unsigned m);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic push_exp(input logic [15:0] v, input int t);
    exp_t e;
    int   sv;
    sv    = int'($signed(v));
    e.neg = (sv < 0);
    e.bcd = to_bcd(int'(sv < 0 ? -sv : sv));
    e.t   = t;
    q[0].push_back(e);
    e.neg = 1'b0;
    e.bcd = to_bcd(int'(v));
    q[1].push_back(e);
    busy_from  = t;
    busy_until = t + LAT;
  endtask

  task automatic check_unit(input int k, input logic done, input logic busy,
                            input logic neg, input logic [19:0] bcd);
    exp_t e;
    logic exp_busy;
    if (rst_seen) begin
      m_bcd[k] = '0;
      m_neg[k] = 1'b0;
    end
    exp_busy = (cyc >= busy_from) && (cyc <= busy_until);
    checks++;
    if (busy !== exp_busy) begin
      failures++;
      $display("FAIL busy unit%0d cyc=%0d: got %b want %b", k, cyc, busy, exp_busy);
    end
    if (done === 1'b1) begin
      checks++;
      if (q[k].size() == 0) begin
        failures++;
        $display("FAIL unexpected_done unit%0d cyc=%0d: got done=1 want none", k, cyc);
      end else begin
        e = q[k].pop_front();
        m_bcd[k] = e.bcd;
        m_neg[k] = e.neg;
        if (cyc - e.t != LAT) begin
          failures++;
          $display("FAIL latency unit%0d: got %0d want %0d", k, cyc - e.t, LAT);
        end
      end
    end
    checks++;
    if (bcd !== m_bcd[k] || neg !== m_neg[k]) begin
      failures++;
      $display("FAIL result unit%0d cyc=%0d done=%b: got bcd=%h neg=%b want bcd=%h neg=%b",
               k, cyc, done, bcd, neg, m_bcd[k], m_neg[k]);
    end
  endtask

  always @(negedge clk) begin
    check_unit(0, bus_s.done, bus_s.busy, bus_s.neg, bus_s.bcd);
    check_unit(1, bus_u.done, bus_u.busy, bus_u.neg, bus_u.bcd);
  end

  task automatic set_in(input logic s, input logic [15:0] v);
    bus_s.start = s; bus_s.value = v;
    bus_u.start = s; bus_u.value = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string what);
    checks++;
    failures++;
    $display("FAIL timeout_%s cyc=%0d: got no event want event within bound", what, cyc);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus_s.busy !== 1'b0) begin
      tick();
      n++;
      if (n > 100) begin
        timeout("idle");
        break;
      end
    end
  endtask

  task automatic convert(input logic [15:0] v, input bit hold);
    wait_idle();
    set_in(1'b1, v);
    push_exp(v, cyc + 1);
    tick();
    if (!hold) set_in(1'b0, v);
  endtask

  initial begin
    logic [15:0] rv;
    int n;
    set_in(1'b0, 16'h0000);
    m_bcd[0] = '0; m_bcd[1] = '0;
    m_neg[0] = 1'b0; m_neg[1] = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    convert(16'd0, 1'b0);
    convert(16'd12345, 1'b0);
    convert(16'hFFFF, 1'b0);
    convert(16'h8000, 1'b0);

    // Start held through busy with a changed value: one result, then back-to-back.
    convert(16'd32767, 1'b1);
    set_in(1'b1, 16'd5);
    n = 0;
    while (bus_s.done !== 1'b1) begin
      tick();
      n++;
      if (n > 100) begin
        timeout("done");
        break;
      end
    end
    tick();
    push_exp(16'd5, cyc + 1);
    tick();
    set_in(1'b0, 16'd0);

    // Reset part-way through the shift phase: no done, outputs cleared.
    convert(16'd999, 1'b0);
    repeat (7) tick();
    rst = 1'b1;
    q[0].delete();
    q[1].delete();
    if (busy_until > cyc) busy_until = cyc;
    tick();
    rst = 1'b0;
    tick();
    convert(16'd999, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rv = 16'($urandom);
      if (i % 10 == 3) rv = 16'h7FFF;
      if (i % 10 == 7) rv = 16'h8001;
      repeat ($urandom_range(0, 3)) tick();
      convert(rv, 1'b0);
    end

    wait_idle();
    repeat (5) tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (q[k].size() != 0) begin
        failures++;
        $display("FAIL pending unit%0d: got %0d outstanding want 0", k, q[k].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
